// File: rtl/rom_image_loader_pkg.sv
// Shared definitions for the ROM image loader: FSM state encoding and ROM geometry defaults.
package rom_image_loader_pkg;

  localparam int unsigned LD_ADDR_W = 6;
  localparam int unsigned LD_DATA_W = 32;
  localparam int unsigned LD_RD_LAT = 1;
  localparam int unsigned ROM_DEPTH = 1 << LD_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_WFLUSH = 3'd2,
    ST_VERIFY = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/rom_image_loader_sum_acc.sv
// Wraparound accumulator (sum_acc): synchronous clear has priority over accumulate.
module rom_image_loader_sum_acc #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Accumulate modulo 2**W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + d;
  end

endmodule

// File: rtl/rom_image_loader.sv
// Streams an image into PMEM/EMEM over the ROM-load port, reads it back to verify,
// reports done/err/checksum and holds the core in reset until a verified PMEM image exists.
module rom_image_loader
  import rom_image_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = LD_ADDR_W,
  parameter int unsigned DATA_W = LD_DATA_W,
  parameter int unsigned RD_LAT = LD_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sel_in,
  input  logic [ADDR_W:0]   len_in,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              rom_we,
  output logic              rom_select,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wd,
  input  logic [DATA_W-1:0] rom_rd,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned      IDX_W     = ADDR_W + 1;
  localparam logic [IDX_W-1:0] DEPTH     = IDX_W'(1) << ADDR_W;
  localparam logic             WAIT_LAST = 1'(RD_LAT);

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx, idx_d, len, len_d;
  logic                wcnt, wcnt_d;
  logic                pmem_ok, pmem_ok_d;
  logic                src_ready_d, rom_we_d, rom_select_d, cpu_rst_d;
  logic                busy_d, done_d, err_d;
  logic [ADDR_W-1:0]   rom_addr_d;
  logic [DATA_W-1:0]   rom_wd_d, checksum_d;
  logic                sum_clr, sum_en, vsum_en;
  logic [DATA_W-1:0]   sum_q, vsum_q;
  logic [IDX_W-1:0]    idx_inc, len_last;
  logic                handshake, sample;

  assign idx_inc   = idx + IDX_W'(1);
  assign len_last  = len - IDX_W'(1);
  assign handshake = src_valid & src_ready;
  assign sample    = (wcnt == WAIT_LAST);

  // Running sum of accepted stream words
  rom_image_loader_sum_acc #(.W(DATA_W)) u_sum (
    .clk (clk),
    .rst (rst),
    .clr (sum_clr),
    .en  (sum_en),
    .d   (src_data),
    .q   (sum_q)
  );

  // Running sum of words read back during verify
  rom_image_loader_sum_acc #(.W(DATA_W)) u_vsum (
    .clk (clk),
    .rst (rst),
    .clr (sum_clr),
    .en  (vsum_en),
    .d   (rom_rd),
    .q   (vsum_q)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      len        <= '0;
      wcnt       <= 1'b0;
      pmem_ok    <= 1'b0;
      src_ready  <= 1'b0;
      rom_we     <= 1'b0;
      rom_select <= 1'b0;
      rom_addr   <= '0;
      rom_wd     <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      checksum   <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      len        <= len_d;
      wcnt       <= wcnt_d;
      pmem_ok    <= pmem_ok_d;
      src_ready  <= src_ready_d;
      rom_we     <= rom_we_d;
      rom_select <= rom_select_d;
      rom_addr   <= rom_addr_d;
      rom_wd     <= rom_wd_d;
      cpu_rst    <= cpu_rst_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      checksum   <= checksum_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    len_d        = len;
    wcnt_d       = wcnt;
    pmem_ok_d    = pmem_ok;
    src_ready_d  = 1'b0;
    rom_we_d     = 1'b0;
    rom_select_d = rom_select;
    rom_addr_d   = rom_addr;
    rom_wd_d     = rom_wd;
    cpu_rst_d    = cpu_rst;
    busy_d       = busy;
    done_d       = 1'b0;
    err_d        = err;
    checksum_d   = checksum;
    sum_clr      = 1'b0;
    sum_en       = 1'b0;
    vsum_en      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          checksum_d = '0;
          if (len_in == '0 || len_in > DEPTH) begin
            // Illegal length: report immediately without touching the ROM
            err_d     = 1'b1;
            done_d    = 1'b1;
            cpu_rst_d = ~pmem_ok;
            state_d   = ST_DONE;
          end else begin
            len_d        = len_in;
            rom_select_d = sel_in;
            err_d        = 1'b0;
            sum_clr      = 1'b1;
            idx_d        = '0;
            busy_d       = 1'b1;
            cpu_rst_d    = 1'b1;
            src_ready_d  = 1'b1;
            state_d      = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        src_ready_d = 1'b1;
        if (handshake) begin
          rom_we_d   = 1'b1;
          rom_addr_d = idx[ADDR_W-1:0];
          rom_wd_d   = src_data;
          sum_en     = 1'b1;
          idx_d      = idx_inc;
          if (idx == len_last) begin
            src_ready_d = 1'b0;
            state_d     = ST_WFLUSH;
          end
        end
      end

      ST_WFLUSH: begin
        // Last write is on the port; present address 0 for readback
        idx_d      = '0;
        wcnt_d     = 1'b0;
        rom_addr_d = '0;
        state_d    = ST_VERIFY;
      end

      ST_VERIFY: begin
        if (sample) begin
          vsum_en    = 1'b1;
          wcnt_d     = 1'b0;
          idx_d      = idx_inc;
          rom_addr_d = idx_inc[ADDR_W-1:0];
          if (idx == len_last) state_d = ST_CHECK;
        end else begin
          wcnt_d = wcnt + 1'b1;
        end
      end

      ST_CHECK: begin
        err_d      = (vsum_q != sum_q);
        checksum_d = sum_q;
        if (!rom_select) pmem_ok_d = (vsum_q == sum_q);
        cpu_rst_d  = ~pmem_ok_d;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_image_loader.sv
// Self-checking bench for rom_image_loader: ROM memory model, per-load transaction model
// and a per-cycle compare process.
module tb_rom_image_loader;

  localparam int RD_LAT = 1;
  localparam int BIG    = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sel_in = 1'b0;
  logic [6:0]  len_in = '0;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = '0;
  logic        src_ready, rom_we, rom_select, cpu_rst, busy, done, err;
  logic [5:0]  rom_addr;
  logic [31:0] rom_wd, checksum;
  logic [31:0] rom_rd = '0;

  rom_image_loader #(.ADDR_W(6), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sel_in     (sel_in),
    .len_in     (len_in),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .rom_we     (rom_we),
    .rom_select (rom_select),
    .rom_addr   (rom_addr),
    .rom_wd     (rom_wd),
    .rom_rd     (rom_rd),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        sel;
  } wr_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic chk_on = 1'b0;

  // ROM model state
  logic [31:0] mem [2][64];
  logic        corrupt_en = 1'b0;
  logic [5:0]  corrupt_addr = '0;

  // Transaction model state
  wr_t         wq[$];
  logic [31:0] words [64];
  int          m_start = 0, m_done = 0, m_last = 0;
  logic        m_any = 1'b0, m_good = 1'b0, m_sel = 1'b0;
  logic        m_err = 1'b0, m_pmem_ok = 1'b0, m_before = 1'b1, m_after = 1'b1;
  logic [31:0] m_chk = '0;
  int          n_wr = 0, last_wr_addr = -1, obs_done = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ROM: registered read (one cycle latency), optional single-word readback corruption
  always @(posedge clk) begin
    if (rom_we) mem[rom_select][rom_addr] <= rom_wd;
    rom_rd <= mem[rom_select][rom_addr] ^
              ((corrupt_en && rom_addr == corrupt_addr) ? 32'h4 : 32'h0);
  end

  // Per-cycle comparison against the transaction model
  always @(negedge clk) begin
    logic e_busy, e_ready, e_done, e_cpu;
    if (rst && chk_on) begin
      e_busy  = m_good && cyc > m_start && cyc < m_done;
      e_ready = m_good && cyc > m_start && cyc <= m_last;
      e_done  = m_any && cyc == m_done;
      if (cyc <= m_start)    e_cpu = m_before;
      else if (cyc < m_done) e_cpu = m_good ? 1'b1 : m_before;
      else                   e_cpu = m_after;
      chk("busy", busy, e_busy);
      chk("src_ready", src_ready, e_ready);
      chk("done", done, e_done);
      chk("cpu_rst", cpu_rst, e_cpu);
      if (e_busy) chk("rom_select", rom_select, m_sel);
      if (cyc > m_start) begin
        chk("err", err, (cyc >= m_done) ? m_err : 1'b0);
        chk("checksum", checksum, (cyc >= m_done) ? m_chk : 32'h0);
      end
      if (done) obs_done = cyc;
      if (rom_we) begin
        n_wr++;
        last_wr_addr = int'(rom_addr);
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", rom_addr, e.addr);
          chk("wr_data", rom_wd, e.data);
          chk("wr_sel", rom_select, e.sel);
        end
      end
    end
  end

  task automatic model_reset();
    m_any = 1'b0; m_good = 1'b0; m_pmem_ok = 1'b0;
    m_before = 1'b1; m_after = 1'b1; m_err = 1'b0; m_chk = '0;
    m_start = 0; m_done = 0; m_last = 0;
    wq.delete();
  endtask

  task automatic check_reset_values();
    chk("rst_src_ready", src_ready, 0);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_rom_select", rom_select, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_wd", rom_wd, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_checksum", checksum, 0);
  endtask

  // One load request: mode 0 = no stalls, 1 = valid every other cycle, 2 = random stalls.
  // corrupt >= 0 corrupts that word on readback; abort_at >= 0 resets after that many handshakes.
  task automatic run_load(input logic sel, input int len, input int mode,
                          input int corrupt, input int abort_at);
    int k, guard;
    logic good, v;
    logic [31:0] s;
    @(posedge clk); #1;
    good = (len >= 1 && len <= 64);
    s = '0;
    if (good) for (int i = 0; i < len; i++) s = s + words[i];
    corrupt_en   = (corrupt >= 0);
    corrupt_addr = 6'(corrupt);
    m_before = m_after;
    m_start  = cyc;
    m_any    = 1'b1;
    m_good   = good;
    m_sel    = sel;
    m_last   = good ? BIG : 0;
    m_done   = good ? BIG : cyc + 1;
    m_err    = good ? (corrupt >= 0) : 1'b1;
    m_chk    = good ? s : 32'h0;
    if (good && !sel) m_pmem_ok = (corrupt < 0);
    m_after  = ~m_pmem_ok;
    if (good) for (int i = 0; i < len; i++) wq.push_back('{6'(i), words[i], sel});
    n_wr = 0; last_wr_addr = -1; obs_done = -1;
    start = 1'b1; sel_in = sel; len_in = 7'(len);
    @(posedge clk); #1;
    start = 1'b0; sel_in = $urandom_range(0, 1); len_in = 7'($urandom);
    k = 0; guard = 0;
    while (good && k < len && guard < 1000) begin
      if (abort_at >= 0 && k == abort_at) begin
        src_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        corrupt_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      src_valid = v;
      src_data  = v ? words[k] : $urandom;
      if (v && src_ready) begin
        k++;
        if (k == len) begin
          m_last = cyc;
          m_done = cyc + 2 + len * (RD_LAT + 1) + 1;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000) chk("stream_timeout", 0, 1);
    src_valid = 1'b0;
    guard = 0;
    while (cyc <= m_done + 1 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) chk("done_timeout", 0, 1);
    chk("writes_outstanding", wq.size(), 0);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) words[i] = $urandom;
  endtask

  initial begin
    int len, cor;
    logic sel;
    model_reset();
    for (int s = 0; s < 2; s++) for (int a = 0; a < 64; a++) mem[s][a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b1;
    chk_on = 1'b1;

    // 1) PMEM load 1,2,3,4
    words[0] = 32'd1; words[1] = 32'd2; words[2] = 32'd3; words[3] = 32'd4;
    run_load(1'b0, 4, 0, -1, -1);
    chk("t1_done_cycle", obs_done - m_start, 15);
    chk("t1_checksum", checksum, 32'd10);
    chk("t1_err", err, 0);
    chk("t1_cpu_rst", cpu_rst, 0);
    chk("t1_writes", n_wr, 4);
    chk("t1_last_addr", last_wr_addr, 3);

    // 2) EMEM load
    words[0] = 32'hDEADBEEF; words[1] = 32'h1;
    run_load(1'b1, 2, 0, -1, -1);
    chk("t2_checksum", checksum, 32'hDEADBEF0);
    chk("t2_cpu_rst", cpu_rst, 0);
    chk("t2_done_cycle", obs_done - m_start, 9);

    // 3) full depth with alternate-cycle stalls
    fill_random(64);
    run_load(1'b0, 64, 1, -1, -1);
    chk("t3_writes", n_wr, 64);
    chk("t3_last_addr", last_wr_addr, 63);
    chk("t3_err", err, 0);

    // 4) illegal lengths
    run_load(1'b0, 0, 0, -1, -1);
    chk("t4a_writes", n_wr, 0);
    chk("t4a_done_cycle", obs_done - m_start, 1);
    chk("t4a_err", err, 1);
    run_load(1'b1, 65, 0, -1, -1);
    chk("t4b_writes", n_wr, 0);
    chk("t4b_done_cycle", obs_done - m_start, 1);
    chk("t4b_err", err, 1);

    // 5) corrupted readback, then a good PMEM load
    fill_random(4);
    run_load(1'b0, 4, 0, 2, -1);
    chk("t5_err", err, 1);
    chk("t5_cpu_rst", cpu_rst, 1);
    fill_random(4);
    run_load(1'b0, 4, 2, -1, -1);
    chk("t5b_err", err, 0);
    chk("t5b_cpu_rst", cpu_rst, 0);

    // 6) reset during WRITE at idx 3, then a clean load
    fill_random(8);
    run_load(1'b0, 8, 0, -1, 3);
    chk("t6_cpu_rst_after_abort", cpu_rst, 1);
    fill_random(8);
    run_load(1'b0, 8, 2, -1, -1);
    chk("t6_writes", n_wr, 8);
    chk("t6_cpu_rst", cpu_rst, 0);

    // randomized loads
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 64);
      sel = 1'($urandom_range(0, 1));
      cor = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      fill_random(len);
      run_load(sel, len, 2, cor, -1);
      chk("rnd_writes", n_wr, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
